// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner of the shared snooping bus. It broadcasts the
//   winning op/address, collects snooper writeback/abort responses and sequences the
//   memory phase (writeback, then block fetch), then pulses done to the grantee.
// Latency: a request seen at edge k gets grant and bus_valid in cycle k+1. With no
//   memory phase, done arrives SNOOP_LAT+2 cycles after that edge.
// Backpressure: req is held until done. The memory phase stalls in WB/MEM until
//   mem_ack; mem_ack in the first cycle of mem_req is accepted.
// Ports: clock/reset (sync, active-low); req/req_op/req_addr per cache (packed);
//   grant, bus_valid/op/addr/src broadcast; snoop_wb/snoop_abort from snoopers;
//   mem_req/mem_we/mem_addr/mem_ack to memory; done per cache.
// Optional: `define ARB_STATS_EN adds saturating txn_count / wb_count outputs.
module snoop_bus_arbiter #(
  parameter int N_CACHES  = 4,
  parameter int ADDR_W    = 8,
  parameter int SNOOP_LAT = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CACHES-1:0]        req,
  input  logic [2*N_CACHES-1:0]      req_op,
  input  logic [ADDR_W*N_CACHES-1:0] req_addr,
  output logic [N_CACHES-1:0]        grant,
  output logic                       bus_valid,
  output logic [2:0]                 bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [2:0]                 bus_src,
  input  logic [N_CACHES-1:0]        snoop_wb,
  input  logic [N_CACHES-1:0]        snoop_abort,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  output logic [N_CACHES-1:0]        done
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                txn_count,
  output logic [15:0]                wb_count
`endif
);

  localparam int IDX_W = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
  localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BCAST = 3'd1;
  localparam logic [2:0] S_SNOOP = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [N_CACHES-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [2:0]          src_q, src_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wb_any_q, wb_any_d;
  logic                abort_any_q, abort_any_d;

  logic [IDX_W-1:0]    win;
  logic                win_vld;
  logic                is_miss;

  // Round-robin scan: start one past the last winner and wrap.
  always_comb begin
    int scan_idx;
    scan_idx = 0;
    win      = '0;
    win_vld  = 1'b0;
    for (int i = 1; i <= N_CACHES; i++) begin
      scan_idx = (int'(rr_q) + i) % N_CACHES;
      if (!win_vld && req[scan_idx[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win     = scan_idx[IDX_W-1:0];
      end
    end
  end

  // Read and write misses fetch the block (write-allocate); invalidate/null never do.
  assign is_miss = (op_q == 2'b01) || (op_q == 2'b10);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    src_d       = src_q;
    op_d        = op_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    wb_any_d    = wb_any_q;
    abort_any_d = abort_any_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          src_d        = 3'(win);
          op_d         = req_op[2*win +: 2];
          addr_d       = req_addr[ADDR_W*win +: ADDR_W];
          rr_d         = win;
          state_d      = S_BCAST;
        end
      end
      S_BCAST: begin
        wb_any_d    = 1'b0;
        abort_any_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_SNOOP;
      end
      S_SNOOP: begin
        // The grantee's own response lines are masked out.
        wb_any_d    = wb_any_q    | (|(snoop_wb    & ~grant_q));
        abort_any_d = abort_any_q | (|(snoop_abort & ~grant_q));
        if (cnt_q == CNT_W'(SNOOP_LAT - 1)) begin
          if (wb_any_d)                     state_d = S_WB;
          else if (is_miss && !abort_any_d) state_d = S_MEM;
          else                              state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        if (mem_ack) state_d = (is_miss && !abort_any_q) ? S_MEM : S_DONE;
      end
      S_MEM: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_q        <= IDX_W'(N_CACHES - 1);
      src_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      wb_any_q    <= 1'b0;
      abort_any_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      src_q       <= src_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wb_any_q    <= wb_any_d;
      abort_any_q <= abort_any_d;
    end
  end

  // bus_addr/bus_src keep the last owner's values while idle; bus_op does not.
  assign grant     = grant_q;
  assign bus_valid = (state_q == S_BCAST);
  assign bus_op    = (state_q == S_IDLE) ? 3'b000 : {1'b0, op_q};
  assign bus_addr  = addr_q;
  assign bus_src   = src_q;
  assign mem_req   = (state_q == S_WB) || (state_q == S_MEM);
  assign mem_we    = (state_q == S_WB);
  assign mem_addr  = addr_q;
  assign done      = (state_q == S_DONE) ? grant_q : '0;

`ifdef ARB_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;
  logic [15:0] wb_count_q, wb_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    wb_count_d  = wb_count_q;
    if (state_q == S_DONE && txn_count_q != 16'hFFFF)
      txn_count_d = txn_count_q + 16'd1;
    if (state_q == S_WB && mem_ack && wb_count_q != 16'hFFFF)
      wb_count_d = wb_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      txn_count_q <= '0;
      wb_count_q  <= '0;
    end else begin
      txn_count_q <= txn_count_d;
      wb_count_q  <= wb_count_d;
    end
  end

  assign txn_count = txn_count_q;
  assign wb_count  = wb_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed vectors for snoop_bus_arbiter (N_CACHES=4, ADDR_W=8,
//   SNOOP_LAT=2). Inputs change and outputs are sampled on the falling edge.
// Sequence: reset, round-robin burst, read miss, writeback with abort, invalidate
//   with own-line masking, reset during the memory phase.
module tb_snoop_bus_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [31:0] req_addr;
  logic [3:0]  grant;
  logic        bus_valid;
  logic [2:0]  bus_op;
  logic [7:0]  bus_addr;
  logic [2:0]  bus_src;
  logic [3:0]  snoop_wb;
  logic [3:0]  snoop_abort;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [3:0]  done;
`ifdef ARB_STATS_EN
  logic [15:0] txn_count;
  logic [15:0] wb_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [3:0] rr_exp;

  snoop_bus_arbiter #(.N_CACHES(4), .ADDR_W(8), .SNOOP_LAT(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .grant      (grant),
    .bus_valid  (bus_valid),
    .bus_op     (bus_op),
    .bus_addr   (bus_addr),
    .bus_src    (bus_src),
    .snoop_wb   (snoop_wb),
    .snoop_abort(snoop_abort),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .done       (done)
`ifdef ARB_STATS_EN
    ,
    .txn_count  (txn_count),
    .wb_count   (wb_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    req         = '0;
    req_op      = '0;
    req_addr    = '0;
    snoop_wb    = '0;
    snoop_abort = '0;
    mem_ack     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_grant", grant, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_op", bus_op, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_src", bus_src, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;

    // Round-robin: all four request null ops; expect 0,1,2,3,0
    req      = 4'b1111;
    req_op   = 8'h00;
    req_addr = 32'h44_33_22_11;
    for (int t = 0; t < 5; t++) begin
      step();  // BCAST
      rr_exp = 4'b0001 << (t % 4);
      chk("rr_grant", grant, rr_exp);
      chk("rr_bus_valid", bus_valid, 1);
      chk("rr_bus_src", bus_src, t % 4);
      chk("rr_bus_op", bus_op, 3'b000);
      step();
      step();
      chk("rr_grant_hold", grant, rr_exp);
      step();  // DONE
      chk("rr_done", done, rr_exp);
      if (t == 4) req = 4'b0000;
      step();  // IDLE
      chk("rr_idle_grant", grant, 0);
    end

    // Read miss from cache 0, memory acks in the third cycle of mem_req
    req      = 4'b0001;
    req_op   = 8'b00_00_00_01;
    req_addr = 32'h00_00_34_12;
    step();
    chk("t1_bus_valid", bus_valid, 1);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_bus_op", bus_op, 3'b001);
    chk("t1_bus_addr", bus_addr, 8'h12);
    step();
    chk("t1_bus_valid_1cyc", bus_valid, 0);
    step();
    step();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_addr", mem_addr, 8'h12);
    step();
    chk("t1_mem_req_hold1", mem_req, 1);
    step();
    chk("t1_mem_req_hold2", mem_req, 1);
    mem_ack = 1'b1;
    step();
    chk("t1_done", done, 4'b0001);
    chk("t1_mem_req_off", mem_req, 0);
    mem_ack = 1'b0;
    req     = 4'b0000;
    step();
    chk("t1_idle_done", done, 0);
    chk("t1_idle_bus_op", bus_op, 0);
    chk("t1_idle_addr_hold", bus_addr, 8'h12);

    // Read miss from cache 1; cache 2 must write back and aborts the fetch
    req    = 4'b0010;
    req_op = 8'b00_00_01_00;
    step();
    chk("t2_grant", grant, 4'b0010);
    chk("t2_bus_src", bus_src, 1);
    chk("t2_bus_addr", bus_addr, 8'h34);
    snoop_wb    = 4'b0100;
    snoop_abort = 4'b0100;
    step();
    step();
    snoop_wb    = '0;
    snoop_abort = '0;
    step();
    chk("t2_wb_req", mem_req, 1);
    chk("t2_wb_we", mem_we, 1);
    chk("t2_wb_addr", mem_addr, 8'h34);
    mem_ack = 1'b1;
    step();
    chk("t2_done", done, 4'b0010);
    chk("t2_no_fetch", mem_req, 0);
    mem_ack = 1'b0;
    req     = 4'b0000;
    step();

`ifdef ARB_STATS_EN
    chk("stats_txn", txn_count, 16'd7);
    chk("stats_wb", wb_count, 16'd1);
`endif

    // Invalidate from cache 3; its own writeback line is ignored
    req      = 4'b1000;
    req_op   = 8'b11_00_00_00;
    req_addr = 32'h56_00_34_12;
    step();
    chk("t4_grant", grant, 4'b1000);
    chk("t4_bus_op", bus_op, 3'b011);
    snoop_wb = 4'b1000;
    step();
    chk("t4_no_mem1", mem_req, 0);
    step();
    chk("t4_no_mem2", mem_req, 0);
    step();
    chk("t4_done", done, 4'b1000);
    chk("t4_no_mem3", mem_req, 0);
    snoop_wb = '0;
    req      = 4'b0000;
    step();

    // Reset during the fetch of a read miss from cache 2
    req      = 4'b0100;
    req_op   = 8'b00_01_00_00;
    req_addr = 32'h00_78_00_00;
    step();
    chk("t5_grant", grant, 4'b0100);
    step();
    step();
    step();
    chk("t5_mem_req", mem_req, 1);
    chk("t5_mem_addr", mem_addr, 8'h78);
    reset = 1'b0;
    step();
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_mem_req", mem_req, 0);
    chk("t5_rst_mem_we", mem_we, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_bus_valid", bus_valid, 0);
    chk("t5_rst_bus_addr", bus_addr, 0);
    chk("t5_rst_bus_op", bus_op, 0);
    reset    = 1'b1;
    req      = 4'b0101;
    req_op   = 8'b00_01_00_01;
    req_addr = 32'h00_78_00_9A;
    step();
    chk("t5_rearb_grant", grant, 4'b0001);
    chk("t5_rearb_addr", bus_addr, 8'h9A);
    chk("t5_rearb_no_done", done, 0);
    req   = 4'b0000;
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
